multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multicycle control sequencer for the CPU datapath. Steps each instruction through fetch, decode, execute, memory and writeback, with a ready handshake to memory. Drives PC, IR, memory strobes, flag writes and the register-file write port (wr_en, sel_datain). Decodes the same 5-bit opcode set as the access stage.

Parameters:
OPW, 5, opcode width
WAIT_MAX, 15, maximum cycles spent waiting on mem_ready in one FETCH/MEM visit before a fault

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  leave IDLE/ERR and begin fetching
halt_req  input  1  stop at next instruction boundary (latched)
instr  input  OPW  opcode from IR, valid from DECODE onward
flag_z  input  1  zero flag
flag_n  input  1  negative flag
mem_ready  input  1  memory completes current rd/wr this cycle
ir_load  output  1  load IR from memory data
pc_inc  output  1  PC <= PC+1
pc_load  output  1  PC <= branch target
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
rf_rd_en  output  1  register-file read
flags_we  output  1  update Z/N flags
wr_en  output  1  register-file write enable
sel_datain  output  3  write data select: 1 ALU, 2 load data, 3 call link, 4 callr link
busy  output  1  state not IDLE/ERR
mem_err  output  1  memory timeout fault, sticky
state  output  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERR=6

Behaviour:
- Opcodes: mv=0 add=1 sub=2 cmp=3 ld=4 st=5 jr=8 jzr=9 jnr=10 callr=12 mvi=16 addi=17 subi=18 cmpi=19 mvhi=22 j=24 jz=25 jn=26 call=28. All other opcodes are NOPs.
- Reset (reset=0, async): state=IDLE, halt latch=0, wait counter=0, mem_err=0. All outputs 0.
- Outputs are combinational from state, instr, flags and mem_ready. Unlisted outputs are 0 in each state.
- IDLE: start=1 and halt_req=0 -> FETCH. If halt_req=1 in the same cycle, stay in IDLE.
- FETCH: mem_rd=1. On mem_ready: ir_load=1, pc_inc=1, -> DECODE.
- DECODE: rf_rd_en=1 -> EXEC.
- EXEC:
  - add/addi/sub/subi: flags_we=1 -> WB.
  - mv/mvi/mvhi -> WB.
  - cmp/cmpi: flags_we=1 -> boundary.
  - ld/st -> MEM.
  - j/jr: pc_load=1 -> boundary.
  - jz/jzr: pc_load=flag_z -> boundary.
  - jn/jnr: pc_load=flag_n -> boundary.
  - call/callr -> WB.
  - NOP -> boundary.
- MEM:
  - ld: mem_rd=1; on mem_ready -> WB.
  - st: mem_wr=1; on mem_ready -> boundary.
- WB: wr_en=1.
  - sel_datain=1 for ALU/mv ops, 2 for ld, 3 for call, 4 for callr.
  - call/callr also assert pc_load=1; the link is written before the PC changes.
  - -> boundary.
- Boundary: next state is IDLE if the halt latch is set or halt_req=1, else FETCH. The halt latch sets on halt_req in any non-IDLE state and clears on entering IDLE.
- Latency with zero-wait memory:
  - ALU/mv: 4 cycles.
  - ld: 5 cycles.
  - st, call: 4 cycles.
  - cmp, jumps, NOP: 3 cycles.
- Watchdog:
  - Counter clears on every state change.
  - Counter increments each FETCH/MEM cycle without mem_ready.
  - If a FETCH/MEM cycle arrives with counter=WAIT_MAX-1 and mem_ready=0, the next state is ERR. WAIT_MAX strobe cycles are allowed in total.
  - mem_ready in that same final cycle is honoured (no fault).
- ERR: mem_err=1, all strobes 0. start -> FETCH and clears mem_err; otherwise stay in ERR.
- Reset asserted mid-instruction aborts it; no strobe is asserted after reset.

Test Plan:
- Reset then start, instr=add(1), mem_ready=1 -> states 1,2,3,5,1. EXEC: flags_we=1. WB: wr_en=1, sel_datain=1. pc_inc pulses once.
- ld(4), mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles. WB: wr_en=1, sel_datain=2. Total 8 cycles.
- jz(25) with flag_z=0, then flag_z=1 -> pc_load 0 then 1 in EXEC. No wr_en. 3 cycles each.
- callr(12) -> WB: wr_en=1, sel_datain=4, pc_load=1 in the same cycle. call(28) -> sel_datain=3.
- mem_ready held 0 in FETCH -> after exactly 15 mem_rd cycles state=6, mem_err=1. Then start -> mem_err=0, state=1.
- halt_req pulsed during EXEC of st(5) -> st completes with mem_wr. Next state is IDLE, busy=0. Async reset asserted in MEM -> all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle CPU control sequencer (fetch/decode/exec/mem/wb)
//            with memory ready handshake and a memory-wait watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int OPW      = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           halt_req,
    input  logic [OPW-1:0] instr,
    input  logic           flag_z,
    input  logic           flag_n,
    input  logic           mem_ready,
    output logic           ir_load,
    output logic           pc_inc,
    output logic           pc_load,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           rf_rd_en,
    output logic           flags_we,
    output logic           wr_en,
    output logic [2:0]     sel_datain,
    output logic           busy,
    output logic           mem_err,
    output logic [2:0]     state
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    localparam logic [OPW-1:0] OP_MV    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
    localparam logic [OPW-1:0] OP_CMP   = OPW'(3);
    localparam logic [OPW-1:0] OP_LD    = OPW'(4);
    localparam logic [OPW-1:0] OP_ST    = OPW'(5);
    localparam logic [OPW-1:0] OP_JR    = OPW'(8);
    localparam logic [OPW-1:0] OP_JZR   = OPW'(9);
    localparam logic [OPW-1:0] OP_JNR   = OPW'(10);
    localparam logic [OPW-1:0] OP_CALLR = OPW'(12);
    localparam logic [OPW-1:0] OP_MVI   = OPW'(16);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(17);
    localparam logic [OPW-1:0] OP_SUBI  = OPW'(18);
    localparam logic [OPW-1:0] OP_CMPI  = OPW'(19);
    localparam logic [OPW-1:0] OP_MVHI  = OPW'(22);
    localparam logic [OPW-1:0] OP_J     = OPW'(24);
    localparam logic [OPW-1:0] OP_JZ    = OPW'(25);
    localparam logic [OPW-1:0] OP_JN    = OPW'(26);
    localparam logic [OPW-1:0] OP_CALL  = OPW'(28);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t         cur_state;
    state_t         nxt_state;
    state_t         boundary;
    logic           halt_latch;
    logic [CW-1:0]  wait_cnt;
    logic           wait_last;

    logic is_alu, is_mv, is_cmp, is_ld, is_st;
    logic is_jmp, is_jz, is_jn, is_call, is_callr;

    assign is_alu   = (instr == OP_ADD) || (instr == OP_ADDI) ||
                      (instr == OP_SUB) || (instr == OP_SUBI);
    assign is_mv    = (instr == OP_MV) || (instr == OP_MVI) || (instr == OP_MVHI);
    assign is_cmp   = (instr == OP_CMP) || (instr == OP_CMPI);
    assign is_ld    = (instr == OP_LD);
    assign is_st    = (instr == OP_ST);
    assign is_jmp   = (instr == OP_J) || (instr == OP_JR);
    assign is_jz    = (instr == OP_JZ) || (instr == OP_JZR);
    assign is_jn    = (instr == OP_JN) || (instr == OP_JNR);
    assign is_call  = (instr == OP_CALL);
    assign is_callr = (instr == OP_CALLR);

    assign wait_last = (wait_cnt == CW'(WAIT_MAX - 1));
    assign boundary  = (halt_latch || halt_req) ? IDLE : FETCH;
    assign state     = cur_state;
    assign busy      = (cur_state != IDLE) && (cur_state != ERR);

    always_comb begin
        nxt_state  = cur_state;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        rf_rd_en   = 1'b0;
        flags_we   = 1'b0;
        wr_en      = 1'b0;
        sel_datain = 3'd0;
        case (cur_state)
            IDLE: begin
                if (start && !halt_req) nxt_state = FETCH;
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load   = 1'b1;
                    pc_inc    = 1'b1;
                    nxt_state = DECODE;
                end else if (wait_last) begin
                    nxt_state = ERR;
                end
            end
            DECODE: begin
                rf_rd_en  = 1'b1;
                nxt_state = EXEC;
            end
            EXEC: begin
                if (is_alu) begin
                    flags_we  = 1'b1;
                    nxt_state = WB;
                end else if (is_mv || is_call || is_callr) begin
                    nxt_state = WB;
                end else if (is_cmp) begin
                    flags_we  = 1'b1;
                    nxt_state = boundary;
                end else if (is_ld || is_st) begin
                    nxt_state = MEM;
                end else begin
                    pc_load   = is_jmp || (is_jz && flag_z) || (is_jn && flag_n);
                    nxt_state = boundary;
                end
            end
            MEM: begin
                mem_rd = is_ld;
                mem_wr = is_st;
                if (!(is_ld || is_st)) begin
                    nxt_state = boundary;
                end else if (mem_ready) begin
                    nxt_state = is_ld ? WB : boundary;
                end else if (wait_last) begin
                    nxt_state = ERR;
                end
            end
            WB: begin
                // Link is written this cycle; the PC redirect lands on the same edge.
                wr_en      = 1'b1;
                pc_load    = is_call || is_callr;
                sel_datain = is_ld    ? 3'd2 :
                             is_call  ? 3'd3 :
                             is_callr ? 3'd4 : 3'd1;
                nxt_state  = boundary;
            end
            ERR: begin
                if (start) nxt_state = FETCH;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= IDLE;
            halt_latch <= 1'b0;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
        end else begin
            cur_state <= nxt_state;

            if (nxt_state != cur_state)
                wait_cnt <= '0;
            else if ((cur_state == FETCH || cur_state == MEM) && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;

            if (nxt_state == IDLE)
                halt_latch <= 1'b0;
            else if (halt_req && cur_state != IDLE)
                halt_latch <= 1'b1;

            if (nxt_state == ERR && cur_state != ERR)
                mem_err <= 1'b1;
            else if (cur_state == ERR && start)
                mem_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
